// File: rtl/simd_adder_rr_scheduler.sv
// simd_adder_rr_scheduler
//   Shares one LANES-wide SIMD adder (LATENCY-cycle, ce-gated pipeline) between
//   N_REQ requesters. A round-robin arbiter issues at most one operation per
//   enabled cycle. A tag pipeline follows each operation through the adder so
//   that its result can be steered back to the requester that issued it.
//   A flush request stops new grants and waits until the adder has drained.
//
// Ports
//   ap_clk, ap_rst       clock, synchronous active-high reset
//   ap_ce                global enable; this block is frozen when it is low
//   req_vld/req_a/req_b  per-requester operands, requester i at [W*i +: W]
//   req_rdy              one-hot grant (combinational)
//   flush, flush_done    drain handshake (flush is held until flush_done is seen)
//   add_ce/add_start     enable and issue strobe to the shared adder
//   add_a/add_b, add_z   adder operands and result
//   res_data, res_vld    result word and one-hot owner of that result
//   busy                 at least one operation is inside the adder
//   op_count             transfer counter (present only with SIMD_SCHED_STATS_EN)
//
// Build option
//   SIMD_SCHED_STATS_EN  adds op_count[31:0]: +1 per transfer, wraps, cleared by
//                        reset and when the block leaves DONE for RUN.
//
// LATENCY must be at least 2.

module simd_adder_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LANES   = 4,
  parameter int LW      = 11,
  parameter int LATENCY = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_ce,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ*LANES*LW-1:0]   req_a,
  input  logic [N_REQ*LANES*LW-1:0]   req_b,
  output logic [N_REQ-1:0]            req_rdy,
  input  logic                        flush,
  output logic                        flush_done,
  output logic                        add_ce,
  output logic                        add_start,
  output logic [LANES*LW-1:0]         add_a,
  output logic [LANES*LW-1:0]         add_b,
  input  logic [LANES*LW-1:0]         add_z,
  output logic [LANES*LW-1:0]         res_data,
  output logic [N_REQ-1:0]            res_vld,
  output logic                        busy
`ifdef SIMD_SCHED_STATS_EN
  ,
  output logic [31:0]                 op_count
`endif
);

  localparam int W    = LANES * LW;
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IDW1 = IDW + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_next;

  logic             r_tag_vld [LATENCY];
  logic [IDW-1:0]   r_tag_id  [LATENCY];

  logic             w_grant_en;
  logic             w_found;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW1-1:0]  w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_busy;
  logic             w_pending;

  // Grants only while running, enabled, out of reset and with no flush pending;
  // flush therefore wins over a simultaneous request.
  assign w_grant_en = ap_ce & ~ap_rst & (r_state == S_RUN) & ~flush;

  // Round-robin search starting at r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_idx    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_gnt    = '0;
    if (w_grant_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = IDW1'(r_ptr) + IDW1'(k);
        if (w_idx >= IDW1'(N_REQ)) begin
          w_idx = w_idx - IDW1'(N_REQ);
        end
        if (!w_found && req_vld[w_idx[IDW-1:0]]) begin
          w_found  = 1'b1;
          w_gnt_id = w_idx[IDW-1:0];
        end
      end
      if (w_found) begin
        w_gnt[w_gnt_id] = 1'b1;
      end
    end
  end

  assign w_ptr_next = (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  assign req_rdy   = w_gnt;
  assign add_ce    = ap_ce;
  assign add_start = w_found;
  assign add_a     = w_found ? req_a[w_gnt_id*W +: W] : '0;
  assign add_b     = w_found ? req_b[w_gnt_id*W +: W] : '0;
  assign res_data  = add_z;

  // busy: anything in flight. w_pending: anything that will still be in flight
  // after the next enabled edge (the last stage delivers its result this cycle).
  always_comb begin
    w_busy    = 1'b0;
    w_pending = 1'b0;
    for (int s = 0; s < LATENCY; s++) begin
      w_busy = w_busy | r_tag_vld[s];
      if (s < LATENCY - 1) begin
        w_pending = w_pending | r_tag_vld[s];
      end
    end
  end

  assign busy = w_busy;

  always_comb begin
    res_vld = '0;
    if (ap_ce && !ap_rst && r_tag_vld[LATENCY-1]) begin
      res_vld[r_tag_id[LATENCY-1]] = 1'b1;
    end
  end

  // Control FSM: next state
  always_comb begin
    w_state_next = r_state;
    flush_done   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (flush) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_pending) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        flush_done = 1'b1;
        if (!flush) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  // Control FSM: state register and arbitration pointer
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_RUN;
      r_ptr   <= '0;
    end else if (ap_ce) begin
      r_state <= w_state_next;
      if (w_found) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // Tag pipeline stage 0 captures the issue; later stages shift on enabled cycles.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tag_vld[0] <= 1'b0;
      r_tag_id[0]  <= '0;
    end else if (ap_ce) begin
      r_tag_vld[0] <= w_found;
      r_tag_id[0]  <= w_gnt_id;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_tag_stage
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_id[gi]  <= '0;
        end else if (ap_ce) begin
          r_tag_vld[gi] <= r_tag_vld[gi-1];
          r_tag_id[gi]  <= r_tag_id[gi-1];
        end
      end
    end
  endgenerate

`ifdef SIMD_SCHED_STATS_EN
  logic [31:0] r_op_count;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_op_count <= '0;
    end else if (ap_ce) begin
      if (r_state == S_DONE && w_state_next == S_RUN) begin
        r_op_count <= '0;
      end else if (w_found) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_simd_adder_rr_scheduler.sv
// Bench for simd_adder_rr_scheduler: a stub of the shared 2-cycle ce-gated SIMD
// adder, a queue-based behavioural model compared every cycle, and directed
// vectors with hand-computed literal expectations.

module tb_simd_adder_rr_scheduler;

  localparam int N = 4;
  localparam int W = 44;

  logic           ap_clk;
  logic           ap_rst;
  logic           ap_ce;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_rdy;
  logic           flush;
  logic           flush_done;
  logic           add_ce;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_z;
  logic [W-1:0]   res_data;
  logic [N-1:0]   res_vld;
  logic           busy;
`ifdef SIMD_SCHED_STATS_EN
  logic [31:0]    op_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  simd_adder_rr_scheduler #(.N_REQ(N), .LANES(4), .LW(11), .LATENCY(2)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_ce      (ap_ce),
    .req_vld    (req_vld),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rdy    (req_rdy),
    .flush      (flush),
    .flush_done (flush_done),
    .add_ce     (add_ce),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_z      (add_z),
    .res_data   (res_data),
    .res_vld    (res_vld),
    .busy       (busy)
`ifdef SIMD_SCHED_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(int l0, int l1, int l2, int l3);
    mk = {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
  endfunction

  function automatic logic [W-1:0] lane_add(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[11*k +: 11] = a[11*k +: 11] + b[11*k +: 11];
    end
    return r;
  endfunction

  // Shared adder stub: two ce-gated register stages.
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  always @(posedge ap_clk) begin
    if (add_ce) begin
      r_s1 <= lane_add(add_a, add_b);
      r_s2 <= r_s1;
    end
  end
  assign add_z = r_s2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           left;   // enabled edges until the result is presented
  } item_t;

  item_t       q[$];
  item_t       nq[$];
  item_t       it;
  int          m_ptr  = 0;
  int          m_mode = 0;   // 0 run, 1 draining, 2 done
  logic [31:0] m_cnt  = 0;

  always @(negedge ap_clk) begin
    int           gid;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_res;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic [W-1:0] e_data;
    bit           pend;

    gid = -1; e_rdy = '0; e_res = '0; e_a = '0; e_b = '0; e_data = '0;
    if (ap_ce && !ap_rst && m_mode == 0 && !flush) begin
      for (int k = 0; k < N; k++) begin
        if (gid < 0 && req_vld[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
      end
    end
    if (gid >= 0) begin
      e_rdy[gid] = 1'b1;
      e_a = req_a[gid*W +: W];
      e_b = req_b[gid*W +: W];
    end
    if (ap_ce && !ap_rst) begin
      foreach (q[j]) begin
        if (q[j].left == 0) begin
          e_res[q[j].id] = 1'b1;
          e_data = q[j].data;
        end
      end
    end

    chk("req_rdy",    64'(req_rdy),    64'(e_rdy));
    chk("add_start",  64'(add_start),  64'(gid >= 0));
    chk("add_a",      64'(add_a),      64'(e_a));
    chk("add_b",      64'(add_b),      64'(e_b));
    chk("res_vld",    64'(res_vld),    64'(e_res));
    chk("busy",       64'(busy),       64'(q.size() != 0));
    chk("flush_done", 64'(flush_done), 64'(m_mode == 2));
    chk("add_ce",     64'(add_ce),     64'(ap_ce));
    if (e_res != '0) chk("res_data", 64'(res_data), 64'(e_data));
`ifdef SIMD_SCHED_STATS_EN
    chk("op_count", 64'(op_count), 64'(m_cnt));
`endif
    if (gid >= 0) $display("issue  req=%0d a=%h b=%h", gid, e_a, e_b);
    if (res_vld != '0) $display("result vld=%b data=%h", res_vld, res_data);

    if (ap_rst) begin
      q.delete();
      m_ptr = 0; m_mode = 0; m_cnt = 0;
    end else if (ap_ce) begin
      pend = 1'b0;
      nq.delete();
      foreach (q[j]) begin
        if (q[j].left > 0) begin
          pend = 1'b1;
          it = q[j];
          it.left = it.left - 1;
          nq.push_back(it);
        end
      end
      q = nq;
      if (gid >= 0) begin
        it.id = gid; it.data = lane_add(e_a, e_b); it.left = 1;
        q.push_back(it);
        m_ptr = (gid + 1) % N;
        m_cnt = m_cnt + 1;
      end
      case (m_mode)
        0: if (flush) m_mode = 1;
        1: if (!pend) m_mode = 2;
        default: if (!flush) begin m_mode = 0; m_cnt = 0; end
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    ap_rst = 1'b1; ap_ce = 1'b1; flush = 1'b0; req_vld = '0; req_a = '0; req_b = '0;
    nxt(); nxt();
    @(negedge ap_clk);
    chk("rst_rdy",  64'(req_rdy),    64'd0);
    chk("rst_busy", 64'(busy),       64'd0);
    chk("rst_done", 64'(flush_done), 64'd0);
    nxt();
    ap_rst = 1'b0;

    // 1: single requester
    set_ops(0, mk(1, 2, 3, 4), mk(10, 20, 30, 40));
    req_vld = 4'b0001;
    @(negedge ap_clk);
    chk("t1_rdy", 64'(req_rdy), 64'h1);
    chk("t1_a",   64'(add_a),   64'(mk(1, 2, 3, 4)));
    nxt(); req_vld = '0;
    @(negedge ap_clk);
    chk("t1_early", 64'(res_vld), 64'h0);
    nxt();
    @(negedge ap_clk);
    chk("t1_vld",  64'(res_vld),  64'h1);
    chk("t1_data", 64'(res_data), 64'(mk(11, 22, 33, 44)));
    nxt();

    // 2: all four requesting from reset
    ap_rst = 1'b1; nxt(); ap_rst = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, mk(i + 1, i + 2, i + 3, i + 4), mk(100 * (i + 1), 0, 0, 1));
    req_vld = 4'hf;
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      chk("t2_gnt", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
      if (k >= 2) chk("t2_res", 64'(res_vld), 64'(4'b0001 << ((k - 2) % 4)));
      nxt();
    end
    req_vld = '0;
    nxt(); nxt();

    // 3: lane wrap without carry into the next lane
    set_ops(0, mk(2047, 0, 5, 0), mk(1, 0, 0, 0));
    req_vld = 4'b0001;
    @(negedge ap_clk);
    chk("t3_rdy", 64'(req_rdy), 64'h1);
    nxt(); req_vld = '0;
    nxt();
    @(negedge ap_clk);
    chk("t3_vld",  64'(res_vld),  64'h1);
    chk("t3_data", 64'(res_data), 64'(mk(0, 0, 5, 0)));
    nxt();

    // 4: enable low for three cycles right after issue
    set_ops(2, mk(7, 8, 9, 10), mk(1, 1, 1, 1));
    req_vld = 4'b0100;
    @(negedge ap_clk);
    chk("t4_rdy", 64'(req_rdy), 64'h4);
    nxt(); req_vld = '0; ap_ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("t4_stall", 64'(res_vld), 64'h0);
      nxt();
    end
    ap_ce = 1'b1;
    @(negedge ap_clk);
    chk("t4_early", 64'(res_vld), 64'h0);
    nxt();
    @(negedge ap_clk);
    chk("t4_vld",  64'(res_vld),  64'h4);
    chk("t4_data", 64'(res_data), 64'(mk(8, 9, 10, 11)));
    nxt();

    // 5: flush with two operations in flight (pointer is at 3 here)
    req_vld = 4'b0011;
    @(negedge ap_clk); chk("t5_g0", 64'(req_rdy), 64'h1); nxt();
    @(negedge ap_clk); chk("t5_g1", 64'(req_rdy), 64'h2); nxt();
    req_vld = 4'hf; flush = 1'b1;
    @(negedge ap_clk);
    chk("t5_nogrant", 64'(req_rdy), 64'h0);
    chk("t5_res0",    64'(res_vld), 64'h1);
    nxt();
    @(negedge ap_clk);
    chk("t5_res1",  64'(res_vld),    64'h2);
    chk("t5_done0", 64'(flush_done), 64'h0);
    nxt();
    @(negedge ap_clk);
    chk("t5_done1", 64'(flush_done), 64'h1);
    chk("t5_idle",  64'(busy),       64'h0);
    nxt();
    nxt();
    flush = 1'b0;
    @(negedge ap_clk);
    chk("t5_hold", 64'(flush_done), 64'h1);
    chk("t5_rdy0", 64'(req_rdy),    64'h0);
    nxt();
    @(negedge ap_clk);
    chk("t5_resume", 64'(req_rdy), 64'h4);
    nxt();

    // 6: reset with operations in flight
    nxt();
    ap_rst = 1'b1;
    nxt();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t6_rdy",  64'(req_rdy), 64'h1);
    chk("t6_res0", 64'(res_vld), 64'h0);
`ifdef SIMD_SCHED_STATS_EN
    chk("t6_cnt", 64'(op_count), 64'h0);
`endif
    nxt(); req_vld = '0;
    @(negedge ap_clk);
    chk("t6_res1", 64'(res_vld), 64'h0);
    nxt();
    @(negedge ap_clk);
    chk("t6_res2", 64'(res_vld), 64'h1);
    nxt();

    // mixed traffic with enable gaps, checked by the model each cycle
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N; i++) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        set_ops(i, ra, rb);
      end
      req_vld = 4'($urandom_range(0, 15));
      ap_ce   = ($urandom_range(0, 3) != 0);
      nxt();
    end
    req_vld = '0; ap_ce = 1'b1;
    repeat (4) nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
